// File: rtl/rv64g_l2_pkg.sv
// Shared L2 definitions: TileLink probe caps, probe controller FSM states and
// the core-index width helper.
package rv64g_l2_pkg;

  localparam logic [1:0] TL_CAP_TOT = 2'd0;
  localparam logic [1:0] TL_CAP_TOB = 2'd1;
  localparam logic [1:0] TL_CAP_TON = 2'd2;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StDone
  } probe_state_e;

  // Index width for n clients, never narrower than one bit.
  function automatic int unsigned core_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rv64g_l2_prio_enc.sv
// Lowest-set-bit priority encoder with an any-bit-set flag.
module rv64g_l2_prio_enc #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N-1:0]     i_vec,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  always_comb begin
    o_idx = '0;
    o_any = |i_vec;
    // Scan downwards so the lowest set bit is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (i_vec[i]) o_idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/rv64g_l2_probe_ctrl.sv
// Probe fan-out/collection between the L2 directory lookup and the MSHR: issues one
// B-channel Probe per sharer, collects C-channel ProbeAcks and pulses done_o at the end.
module rv64g_l2_probe_ctrl
  import rv64g_l2_pkg::*;
#(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned CORES  = 4,
  parameter int unsigned CORE_W = core_w(CORES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] start_addr_i,
  input  logic [CORES-1:0]  start_mask_i,
  input  logic [1:0]        start_cap_i,
  output logic              busy_o,
  output logic              set_probes_o,
  output logic [CORES-1:0]  probes_mask_o,
  output logic              b_valid_o,
  input  logic              b_ready_i,
  output logic [CORE_W-1:0] b_core_o,
  output logic [ADDR_W-1:0] b_addr_o,
  output logic [1:0]        b_cap_o,
  input  logic              c_valid_i,
  output logic              c_ready_o,
  input  logic [CORE_W-1:0] c_core_i,
  input  logic [ADDR_W-1:0] c_addr_i,
  input  logic              c_has_data_i,
  output logic              probe_ack_o,
  output logic [CORE_W-1:0] probe_ack_id_o,
  output logic              dirty_o,
  output logic              err_o,
  output logic              done_o
);

  probe_state_e      r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [CORES-1:0]  r_mask;
  logic [1:0]        r_cap;
  logic [CORES-1:0]  r_to_issue;
  logic [CORES-1:0]  r_ack_pend;
  logic              r_set_probes;
  logic              r_probe_ack;
  logic [CORE_W-1:0] r_probe_ack_id;
  logic              r_dirty;
  logic              r_err;
  logic              r_done;

  logic [CORE_W-1:0] w_enc_idx;
  logic              w_enc_any;
  logic [CORES-1:0]  w_b_sel;
  logic [CORES-1:0]  w_c_sel;
  logic              w_b_fire;
  logic              w_c_fire;
  logic              w_c_ok;
  logic [CORES-1:0]  w_to_issue_nxt;
  logic [CORES-1:0]  w_ack_pend_nxt;

  rv64g_l2_prio_enc #(
    .N     (CORES),
    .IDX_W (CORE_W)
  ) u_prio_enc (
    .i_vec (r_to_issue),
    .o_idx (w_enc_idx),
    .o_any (w_enc_any)
  );

  // One-hot selects; an out-of-range core index shifts out to zero and never matches.
  assign w_b_sel  = CORES'(1) << w_enc_idx;
  assign w_c_sel  = CORES'(1) << c_core_i;
  assign w_b_fire = (r_state == StIssue) && w_enc_any && b_ready_i;
  assign w_c_fire = c_valid_i && ((r_state == StIssue) || (r_state == StWait));
  assign w_c_ok   = w_c_fire && (|(w_c_sel & r_ack_pend & ~r_to_issue)) && (c_addr_i == r_addr);

  assign w_to_issue_nxt = w_b_fire ? (r_to_issue & ~w_b_sel) : r_to_issue;
  assign w_ack_pend_nxt = w_c_ok ? (r_ack_pend & ~w_c_sel) : r_ack_pend;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= StIdle;
      r_addr         <= '0;
      r_mask         <= '0;
      r_cap          <= '0;
      r_to_issue     <= '0;
      r_ack_pend     <= '0;
      r_set_probes   <= 1'b0;
      r_probe_ack    <= 1'b0;
      r_probe_ack_id <= '0;
      r_dirty        <= 1'b0;
      r_err          <= 1'b0;
      r_done         <= 1'b0;
    end else begin
      r_set_probes   <= 1'b0;
      r_done         <= 1'b0;
      r_probe_ack    <= w_c_ok;
      r_probe_ack_id <= w_c_ok ? c_core_i : '0;
      if (w_c_ok && c_has_data_i) r_dirty <= 1'b1;
      if (w_c_fire && !w_c_ok)    r_err   <= 1'b1;
      case (r_state)
        StIdle: begin
          if (start_i) begin
            r_addr     <= start_addr_i;
            r_mask     <= start_mask_i;
            r_cap      <= start_cap_i;
            r_to_issue <= start_mask_i;
            r_ack_pend <= start_mask_i;
            r_dirty    <= 1'b0;
            r_err      <= 1'b0;
            if (start_mask_i == '0) begin
              r_state <= StDone;
              r_done  <= 1'b1;
            end else begin
              r_state      <= StIssue;
              r_set_probes <= 1'b1;
            end
          end
        end
        StIssue: begin
          r_to_issue <= w_to_issue_nxt;
          r_ack_pend <= w_ack_pend_nxt;
          if (w_to_issue_nxt == '0) begin
            if (w_ack_pend_nxt == '0) begin
              r_state <= StDone;
              r_done  <= 1'b1;
            end else begin
              r_state <= StWait;
            end
          end
        end
        StWait: begin
          r_ack_pend <= w_ack_pend_nxt;
          // Jumping straight to DONE lines done_o up with the last probe_ack_o pulse.
          if (w_ack_pend_nxt == '0) begin
            r_state <= StDone;
            r_done  <= 1'b1;
          end
        end
        StDone:  r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  assign busy_o         = (r_state != StIdle);
  assign c_ready_o      = busy_o;
  assign set_probes_o   = r_set_probes;
  assign probes_mask_o  = r_mask;
  assign probe_ack_o    = r_probe_ack;
  assign probe_ack_id_o = r_probe_ack_id;
  assign dirty_o        = r_dirty;
  assign err_o          = r_err;
  assign done_o         = r_done;

  assign b_valid_o = (r_state == StIssue) && w_enc_any;
  assign b_core_o  = b_valid_o ? w_enc_idx : '0;
  assign b_addr_o  = b_valid_o ? r_addr : '0;
  assign b_cap_o   = b_valid_o ? r_cap : '0;

endmodule

// File: tb/tb_rv64g_l2_probe_ctrl.sv
// Self-checking bench for rv64g_l2_probe_ctrl: directed rounds with a queue of expected
// probe_ack ids, popped whenever the DUT reports an ack.
module tb_rv64g_l2_probe_ctrl;
  import rv64g_l2_pkg::*;

  localparam int unsigned ADDR_W = 64;
  localparam int unsigned CORES  = 4;
  localparam int unsigned CORE_W = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start_i;
  logic [ADDR_W-1:0] start_addr_i;
  logic [CORES-1:0]  start_mask_i;
  logic [1:0]        start_cap_i;
  logic              busy_o;
  logic              set_probes_o;
  logic [CORES-1:0]  probes_mask_o;
  logic              b_valid_o;
  logic              b_ready_i;
  logic [CORE_W-1:0] b_core_o;
  logic [ADDR_W-1:0] b_addr_o;
  logic [1:0]        b_cap_o;
  logic              c_valid_i;
  logic              c_ready_o;
  logic [CORE_W-1:0] c_core_i;
  logic [ADDR_W-1:0] c_addr_i;
  logic              c_has_data_i;
  logic              probe_ack_o;
  logic [CORE_W-1:0] probe_ack_id_o;
  logic              dirty_o;
  logic              err_o;
  logic              done_o;

  int n_checks = 0;
  int n_errors = 0;
  int n_done   = 0;
  logic [CORE_W-1:0] exp_ack_q[$];

  always #5 clk = ~clk;

  rv64g_l2_probe_ctrl #(
    .ADDR_W (ADDR_W),
    .CORES  (CORES)
  ) u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start_i        (start_i),
    .start_addr_i   (start_addr_i),
    .start_mask_i   (start_mask_i),
    .start_cap_i    (start_cap_i),
    .busy_o         (busy_o),
    .set_probes_o   (set_probes_o),
    .probes_mask_o  (probes_mask_o),
    .b_valid_o      (b_valid_o),
    .b_ready_i      (b_ready_i),
    .b_core_o       (b_core_o),
    .b_addr_o       (b_addr_o),
    .b_cap_o        (b_cap_o),
    .c_valid_i      (c_valid_i),
    .c_ready_o      (c_ready_o),
    .c_core_i       (c_core_i),
    .c_addr_i       (c_addr_i),
    .c_has_data_i   (c_has_data_i),
    .probe_ack_o    (probe_ack_o),
    .probe_ack_id_o (probe_ack_id_o),
    .dirty_o        (dirty_o),
    .err_o          (err_o),
    .done_o         (done_o)
  );

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Scoreboard side: every ack the DUT reports must match the oldest expected id.
  always @(negedge clk) begin
    if (probe_ack_o) begin
      if (exp_ack_q.size() == 0) check_eq("ack_unexpected", 64'(probe_ack_o), 64'd0);
      else check_eq("ack_id", 64'(probe_ack_id_o), 64'(exp_ack_q.pop_front()));
    end else if (rst_n) begin
      check_eq("ack_id_idle", 64'(probe_ack_id_o), 64'd0);
    end
    if (!b_valid_o && rst_n) check_eq("b_core_idle", 64'(b_core_o), 64'd0);
    if (done_o) begin
      n_done++;
      check_eq("done_with_pending", 64'(exp_ack_q.size()), 64'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_round(input logic [ADDR_W-1:0] addr, input logic [CORES-1:0] mask,
                             input logic [1:0] cap);
    start_i      = 1'b1;
    start_addr_i = addr;
    start_mask_i = mask;
    start_cap_i  = cap;
    tick();
    start_i      = 1'b0;
  endtask

  task automatic send_ack(input logic [CORE_W-1:0] core, input logic [ADDR_W-1:0] addr,
                          input logic data, input logic good);
    c_valid_i    = 1'b1;
    c_core_i     = core;
    c_addr_i     = addr;
    c_has_data_i = data;
    if (good) exp_ack_q.push_back(core);
    tick();
    c_valid_i    = 1'b0;
    c_has_data_i = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start_i = 1'b0; start_addr_i = '0; start_mask_i = '0; start_cap_i = '0;
    b_ready_i = 1'b0; c_valid_i = 1'b0; c_core_i = '0; c_addr_i = '0; c_has_data_i = 1'b0;

    // Reset
    repeat (3) tick();
    @(negedge clk);
    check_eq("rst_busy", 64'(busy_o), 64'd0);
    check_eq("rst_c_ready", 64'(c_ready_o), 64'd0);
    check_eq("rst_b_valid", 64'(b_valid_o), 64'd0);
    check_eq("rst_set_probes", 64'(set_probes_o), 64'd0);
    check_eq("rst_mask", 64'(probes_mask_o), 64'd0);
    check_eq("rst_probe_ack", 64'(probe_ack_o), 64'd0);
    check_eq("rst_flags", {61'd0, dirty_o, err_o, done_o}, 64'd0);
    tick();
    rst_n = 1'b1;

    // Basic round, mask 1101, no backpressure
    b_ready_i = 1'b1;
    start_round(64'h1000, 4'b1101, TL_CAP_TON);
    @(negedge clk);
    check_eq("t2_set_probes", 64'(set_probes_o), 64'd1);
    check_eq("t2_mask", 64'(probes_mask_o), 64'hd);
    check_eq("t2_busy", 64'(busy_o), 64'd1);
    check_eq("t2_c_ready", 64'(c_ready_o), 64'd1);
    check_eq("t2_b_valid0", 64'(b_valid_o), 64'd1);
    check_eq("t2_b_core0", 64'(b_core_o), 64'd0);
    check_eq("t2_b_addr", b_addr_o, 64'h1000);
    check_eq("t2_b_cap", 64'(b_cap_o), 64'd2);
    @(negedge clk);
    check_eq("t2_set_probes_pulse", 64'(set_probes_o), 64'd0);
    check_eq("t2_b_core2", 64'(b_core_o), 64'd2);
    @(negedge clk);
    check_eq("t2_b_core3", 64'(b_core_o), 64'd3);
    @(negedge clk);
    check_eq("t2_b_valid_wait", 64'(b_valid_o), 64'd0);
    tick();
    send_ack(2'd2, 64'h1000, 1'b0, 1'b1);
    check_eq("t2_no_early_done", 64'(done_o), 64'd0);
    send_ack(2'd0, 64'h1000, 1'b0, 1'b1);
    send_ack(2'd3, 64'h1000, 1'b0, 1'b1);
    @(negedge clk);
    check_eq("t2_done", 64'(done_o), 64'd1);
    check_eq("t2_last_ack", {62'd0, probe_ack_o, 1'b0} | 64'(probe_ack_id_o), 64'h3 | 64'h2);
    tick();

    // Backpressure plus premature ack from an unprobed core
    b_ready_i = 1'b0;
    start_round(64'h3000, 4'b1001, TL_CAP_TOB);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        c_valid_i = 1'b1; c_core_i = 2'd3; c_addr_i = 64'h3000;
      end else begin
        c_valid_i = 1'b0;
      end
      @(negedge clk);
      check_eq("t3_b_valid_held", 64'(b_valid_o), 64'd1);
      check_eq("t3_b_core_held", 64'(b_core_o), 64'd0);
      check_eq("t3_b_addr_held", b_addr_o, 64'h3000);
      if (i == 3) begin
        check_eq("t3_err", 64'(err_o), 64'd1);
        check_eq("t3_no_ack", 64'(probe_ack_o), 64'd0);
      end
      tick();
    end
    c_valid_i = 1'b0;
    b_ready_i = 1'b1;
    tick();
    tick();
    send_ack(2'd0, 64'h3000, 1'b0, 1'b1);
    send_ack(2'd3, 64'h3000, 1'b0, 1'b1);
    @(negedge clk);
    check_eq("t3_done", 64'(done_o), 64'd1);
    check_eq("t3_err_sticky", 64'(err_o), 64'd1);
    tick();

    // Empty mask
    start_round(64'h0, 4'b0000, TL_CAP_TOT);
    @(negedge clk);
    check_eq("t4_done", 64'(done_o), 64'd1);
    check_eq("t4_no_set_probes", 64'(set_probes_o), 64'd0);
    check_eq("t4_no_b_valid", 64'(b_valid_o), 64'd0);
    check_eq("t4_err_cleared", 64'(err_o), 64'd0);
    tick();
    @(negedge clk);
    check_eq("t4_done_pulse", 64'(done_o), 64'd0);
    check_eq("t4_busy_idle", 64'(busy_o), 64'd0);
    tick();

    // ProbeAckData and address mismatch
    start_round(64'h1000, 4'b0010, TL_CAP_TOT);
    tick();
    send_ack(2'd1, 64'h2000, 1'b0, 1'b0);
    @(negedge clk);
    check_eq("t5_addr_err", 64'(err_o), 64'd1);
    check_eq("t5_addr_no_ack", 64'(probe_ack_o), 64'd0);
    tick();
    send_ack(2'd1, 64'h1000, 1'b1, 1'b1);
    @(negedge clk);
    check_eq("t5_done", 64'(done_o), 64'd1);
    check_eq("t5_dirty", 64'(dirty_o), 64'd1);
    tick();
    start_round(64'h0, 4'b0000, TL_CAP_TOT);
    @(negedge clk);
    check_eq("t5_dirty_cleared", 64'(dirty_o), 64'd0);
    tick();

    // Reset in WAIT aborts the round
    start_round(64'h4000, 4'b1000, TL_CAP_TOT);
    tick();
    @(negedge clk);
    check_eq("t6_wait_busy", 64'(busy_o), 64'd1);
    check_eq("t6_wait_b_valid", 64'(b_valid_o), 64'd0);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("t6_abort_no_done", 64'(done_o), 64'd0);
      check_eq("t6_abort_idle", 64'(busy_o), 64'd0);
    end
    tick();
    start_round(64'h5000, 4'b0001, TL_CAP_TOT);
    @(negedge clk);
    check_eq("t6_restart_b_core", 64'(b_core_o), 64'd0);
    check_eq("t6_restart_b_addr", b_addr_o, 64'h5000);
    tick();
    send_ack(2'd0, 64'h5000, 1'b0, 1'b1);
    @(negedge clk);
    check_eq("t6_done", 64'(done_o), 64'd1);
    tick();
    check_eq("done_count", 64'(n_done), 64'd6);
    check_eq("ack_queue_drained", 64'(exp_ack_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule
